cmd_packet_decoder: RTL
=======================

CMD_PACKET_DECODER -- requirements
Module: cmd_packet_decoder

Interface
REQ-001 Parameter DATA_WIDTH, default 64: data-BRAM word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter OP_WIDTH, default 8: op-BRAM word width in bits; SHALL be a multiple of 8.
REQ-003 Parameter ADDR_WIDTH, default 16: write-address width; SHALL be in the range 1..16.
REQ-004 Parameter TIMEOUT_CYCLES, default 100000: idle cycles allowed mid-packet before abort.
REQ-005 clk_in  input  1  single clock; all state SHALL be clocked on its rising edge.
REQ-006 rst_in  input  1  asynchronous, active-low reset.
REQ-007 rx_valid_in  input  1  one-cycle strobe from the UART receiver; a byte is present.
REQ-008 rx_byte_in  input  8  received byte; qualified by rx_valid_in.
REQ-009 wr_data_valid_out  output  1  one-cycle data-BRAM write strobe.
REQ-010 wr_op_valid_out  output  1  one-cycle op-BRAM write strobe.
REQ-011 wr_addr_out  output  ADDR_WIDTH  write address; held stable from the header until the next header.
REQ-012 wr_data_out  output  DATA_WIDTH  assembled data word.
REQ-013 wr_op_out  output  OP_WIDTH  assembled op word.
REQ-014 rd_req_out  output  1  one-cycle request to transmit the inference result.
REQ-015 busy_out  output  1  high whenever the state is not IDLE.
REQ-016 err_out  output  1  one-cycle strobe on an unknown opcode or a timeout.

Function
REQ-017 Packet format: byte0 = opcode, byte1 = address[7:0], byte2 = address[15:8], then payload.
  - Opcode 0x00 WR_DATA: DATA_WIDTH/8 payload bytes.
  - Opcode 0x02 WR_OP: OP_WIDTH/8 payload bytes.
  - Opcode 0x07 RD_INFER: no payload.
REQ-018 States: IDLE, ADDR_LO, ADDR_HI, PAYLOAD, EMIT.
  - IDLE -> ADDR_LO on a byte with a legal opcode.
  - ADDR_LO -> ADDR_HI on the next byte.
  - ADDR_HI -> PAYLOAD (WR_DATA, WR_OP) or EMIT (RD_INFER) on the next byte.
  - PAYLOAD -> EMIT on the last payload byte.
  - EMIT -> IDLE unconditionally.
REQ-019 A byte with an illegal opcode received in IDLE SHALL pulse err_out the following cycle; the state SHALL stay IDLE.
REQ-020 Payload packing: little-endian; payload byte k SHALL land in word bits [8k+7:8k].
REQ-021 Address bits above ADDR_WIDTH-1 SHALL be discarded.
REQ-022 In EMIT, exactly one strobe SHALL pulse, chosen by the latched opcode: wr_data_valid_out, wr_op_valid_out or rd_req_out.
  - Latency: the strobe SHALL be high the cycle after the last byte's rx_valid_in.
REQ-023 The payload byte counter SHALL clear on entering PAYLOAD.
  - The count SHALL NOT wrap.
  - Bytes that arrive during EMIT SHALL be treated as byte0 of a new packet; they SHALL NOT be dropped.
REQ-024 wr_data_out and wr_op_out SHALL hold their last assembled values until overwritten by the next payload of the same type.
REQ-025 No back-pressure: the block SHALL accept one byte per cycle on consecutive rx_valid_in strobes.

Reset
REQ-026 While rst_in is low, the state SHALL be IDLE and every output SHALL be 0, including the counters, the latched opcode, address and words.
REQ-027 Reset asserted mid-packet SHALL discard the partial packet and produce no strobe.
  - The first byte after release SHALL be decoded as an opcode.

Configuration
REQ-028 Macro CMD_TIMEOUT_EN, when defined, SHALL add a mid-packet idle counter:
  - The counter SHALL run in ADDR_LO, ADDR_HI and PAYLOAD.
  - It SHALL reset on each rx_valid_in.
  - On reaching TIMEOUT_CYCLES, the block SHALL go to IDLE, pulse err_out for one cycle, and produce no write or read strobe.
REQ-029 Without CMD_TIMEOUT_EN, no counter SHALL exist and a partial packet SHALL wait indefinitely.

Verification
REQ-030 WR_DATA: bytes 00 05 00 then 36 36 36 36 36 36 36 36 -> wr_data_valid_out for 1 cycle, wr_addr_out=0x0005, wr_data_out=0x3636363636363636.
REQ-031 WR_OP: bytes 02 01 00 08 -> wr_op_valid_out for 1 cycle, wr_addr_out=0x0001, wr_op_out=0x08; wr_data_out unchanged.
REQ-032 RD_INFER: bytes 07 00 00 -> rd_req_out for 1 cycle the cycle after byte2; no write strobe.
REQ-033 Illegal opcode: byte 0x55, then packet 02 03 00 17 -> err_out for 1 cycle, then a normal op write to address 3 with value 0x17.
REQ-034 Reset mid-packet: bytes 00 02 00 11 22, rst_in low for 3 cycles, then 02 00 00 0A -> no data strobe, one op write of 0x0A.
REQ-035 With CMD_TIMEOUT_EN and TIMEOUT_CYCLES=50: bytes 00 01, then silence for 60 cycles -> err_out pulses once, busy_out low; the next packet decodes correctly.

Source files
------------

// File: rtl/cmd_packet_decoder.sv
// Byte-stream command decoder: turns UART bytes into data/op BRAM writes and inference read requests.
// Optional mid-packet idle timeout is enabled by defining CMD_TIMEOUT_EN.
module cmd_packet_decoder #(
   parameter int DATA_WIDTH     = 64,
   parameter int OP_WIDTH       = 8,
   parameter int ADDR_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rx_valid_in,
   input  logic [7:0]            rx_byte_in,
   output logic                  wr_data_valid_out,
   output logic                  wr_op_valid_out,
   output logic [ADDR_WIDTH-1:0] wr_addr_out,
   output logic [DATA_WIDTH-1:0] wr_data_out,
   output logic [OP_WIDTH-1:0]   wr_op_out,
   output logic                  rd_req_out,
   output logic                  busy_out,
   output logic                  err_out
);

   // state    | meaning
   // IDLE     | waiting for an opcode byte
   // ADDR_LO  | opcode latched, waiting for address[7:0]
   // ADDR_HI  | waiting for address[15:8]
   // PAYLOAD  | collecting little-endian payload bytes
   // EMIT     | one-cycle strobe; an arriving byte is the next opcode

   localparam logic [7:0] OPC_WR_DATA  = 8'h00;
   localparam logic [7:0] OPC_WR_OP    = 8'h02;
   localparam logic [7:0] OPC_RD_INFER = 8'h07;

   localparam int BUF_W  = (DATA_WIDTH > OP_WIDTH) ? DATA_WIDTH : OP_WIDTH;
   localparam int NB_MAX = BUF_W / 8;
   localparam int CNT_W  = $clog2(NB_MAX + 1);

   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH / 8 - 1);
   localparam logic [CNT_W-1:0] OP_LAST   = CNT_W'(OP_WIDTH / 8 - 1);

   if ((DATA_WIDTH % 8 != 0) || (OP_WIDTH % 8 != 0) || (DATA_WIDTH < 8) || (OP_WIDTH < 8) ||
       (ADDR_WIDTH < 1) || (ADDR_WIDTH > 16) || (TIMEOUT_CYCLES < 1)) begin : g_bad_param
      $error("cmd_packet_decoder: illegal parameter combination");
   end

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR_LO,
      ST_ADDR_HI,
      ST_PAYLOAD,
      ST_EMIT
   } state_t;

   state_t                  state_q, state_d;
   logic [7:0]              opc_q, opc_d;
   logic [15:0]             addr_q, addr_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [BUF_W-1:0]        buf_q, buf_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [OP_WIDTH-1:0]     op_q, op_d;
   logic                    err_q, err_d;
   logic [BUF_W-1:0]        buf_ins;
   logic                    last_byte;

`ifdef CMD_TIMEOUT_EN
   localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(TIMEOUT_CYCLES);
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             mid_pkt;
`endif

   function automatic logic opc_legal(input logic [7:0] opc);
      return (opc == OPC_WR_DATA) || (opc == OPC_WR_OP) || (opc == OPC_RD_INFER);
   endfunction

   always_comb begin
      state_d   = state_q;
      opc_d     = opc_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      buf_d     = buf_q;
      data_d    = data_q;
      op_d      = op_q;
      err_d     = 1'b0;
      buf_ins   = buf_q;
      buf_ins[8*int'(cnt_q) +: 8] = rx_byte_in;
      last_byte = (opc_q == OPC_WR_DATA) ? (cnt_q == DATA_LAST) : (cnt_q == OP_LAST);

      case (state_q)
         ST_IDLE, ST_EMIT: begin
            // EMIT falls through to IDLE but must still decode a back-to-back opcode.
            state_d = ST_IDLE;
            if (rx_valid_in) begin
               if (opc_legal(rx_byte_in)) begin
                  opc_d   = rx_byte_in;
                  state_d = ST_ADDR_LO;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_ADDR_LO: begin
            if (rx_valid_in) begin
               addr_d[7:0] = rx_byte_in;
               state_d     = ST_ADDR_HI;
            end
         end
         ST_ADDR_HI: begin
            if (rx_valid_in) begin
               addr_d[15:8] = rx_byte_in;
               cnt_d        = '0;
               state_d      = (opc_q == OPC_RD_INFER) ? ST_EMIT : ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (rx_valid_in) begin
               buf_d = buf_ins;
               if (last_byte) begin
                  // Commit the whole word at once so the output never shows a half-built value.
                  if (opc_q == OPC_WR_DATA) data_d = buf_ins[DATA_WIDTH-1:0];
                  else                      op_d   = buf_ins[OP_WIDTH-1:0];
                  state_d = ST_EMIT;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

`ifdef CMD_TIMEOUT_EN
      mid_pkt = (state_q == ST_ADDR_LO) || (state_q == ST_ADDR_HI) || (state_q == ST_PAYLOAD);
      tmr_d   = tmr_q;
      if (rx_valid_in) begin
         tmr_d = TMR_INIT;
      end else if (mid_pkt) begin
         if (tmr_q == TMR_W'(1)) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            tmr_d   = TMR_INIT;
         end else begin
            tmr_d = tmr_q - 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= ST_IDLE;
         opc_q   <= '0;
         addr_q  <= '0;
         cnt_q   <= '0;
         buf_q   <= '0;
         data_q  <= '0;
         op_q    <= '0;
         err_q   <= 1'b0;
`ifdef CMD_TIMEOUT_EN
         tmr_q   <= TMR_INIT;
`endif
      end else begin
         state_q <= state_d;
         opc_q   <= opc_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         data_q  <= data_d;
         op_q    <= op_d;
         err_q   <= err_d;
`ifdef CMD_TIMEOUT_EN
         tmr_q   <= tmr_d;
`endif
      end
   end

   assign wr_data_valid_out = (state_q == ST_EMIT) && (opc_q == OPC_WR_DATA);
   assign wr_op_valid_out   = (state_q == ST_EMIT) && (opc_q == OPC_WR_OP);
   assign rd_req_out        = (state_q == ST_EMIT) && (opc_q == OPC_RD_INFER);
   assign wr_addr_out       = addr_q[ADDR_WIDTH-1:0];
   assign wr_data_out       = data_q;
   assign wr_op_out         = op_q;
   assign busy_out          = (state_q != ST_IDLE);
   assign err_out           = err_q;

endmodule
